// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and default timing for the multi-key debouncer
//
// Purpose : FSM state encoding, default debounce/long-press windows and a
//           small helper used by every key channel.
// Ports   : none (package).
// Config  : KEY_LONGPRESS_EN (see key_channel_funcmod) does not affect this file.
package key_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DB_DOWN = 2'd1,
    HELD    = 2'd2,
    DB_UP   = 2'd3
  } key_state_t;

  // Default timing for a 50 MHz CLOCK: 10 ms debounce, 1 s long press.
  localparam int CLK_HZ             = 50_000_000;
  localparam int T_DEBOUNCE_DEFAULT = CLK_HZ / 100;
  localparam int T_LONG_DEFAULT     = CLK_HZ;

  // The debounced level is "pressed" for the whole held phase, including
  // the release debounce window (a release is not believed until confirmed).
  function automatic logic is_pressed(input key_state_t s);
    return (s == HELD) || (s == DB_UP);
  endfunction

endpackage

// File: rtl/key_channel_funcmod.sv
// rtl/key_channel_funcmod.sv - one debounced key channel
//
// Purpose : two-flop synchroniser, 4-state debounce FSM, debounce counter and
//           (with KEY_LONGPRESS_EN defined) a saturating long-press counter.
// Ports   : CLOCK   in  system clock, posedge
//           RESET   in  asynchronous active-low reset
//           KEY     in  raw key pin, active-low, asynchronous
//           PRESS   out one-cycle pulse per confirmed press
//           RELEASE out one-cycle pulse per confirmed release
//           LONG    out one-cycle pulse after T_LONG cycles held (0 if disabled)
//           STATE   out debounced level, 1 = pressed
// Config  : KEY_LONGPRESS_EN - when undefined the long counter is absent,
//           LONG is tied to 0 and T_LONG is ignored.
module key_channel_funcmod
  import key_pkg::*;
#(
  parameter int T_DEBOUNCE = T_DEBOUNCE_DEFAULT,
  parameter int T_LONG     = T_LONG_DEFAULT
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic KEY,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic STATE
);

  localparam int DW = $clog2(T_DEBOUNCE);
  localparam int LW = $clog2(T_LONG + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(T_DEBOUNCE - 1);

  logic            sync1;
  logic            k2;
  key_state_t      state_q, state_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic            press_d;
  logic            release_d;

  // Synchroniser idles high so reset never looks like a press.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b1;
      k2    <= 1'b1;
    end else begin
      sync1 <= KEY;
      k2    <= sync1;
    end
  end

  // Only the synchronised level at the end of the window decides the
  // outcome; bounces inside the window neither restart nor abort it.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        db_cnt_d = '0;
        if (!k2) state_d = DB_DOWN;
      end
      DB_DOWN: begin
        if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          if (!k2) begin
            state_d = HELD;
            press_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      HELD: begin
        db_cnt_d = '0;
        if (k2) state_d = DB_UP;
      end
      DB_UP: begin
        if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          if (k2) begin
            state_d   = IDLE;
            release_d = 1'b1;
          end else begin
            state_d = HELD;
          end
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      PRESS    <= 1'b0;
      RELEASE  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      PRESS    <= press_d;
      RELEASE  <= release_d;
    end
  end

  assign STATE = is_pressed(state_q);

`ifdef KEY_LONGPRESS_EN
  localparam logic [LW-1:0] LONG_MAX  = LW'(T_LONG);
  localparam logic [LW-1:0] LONG_LAST = LW'(T_LONG - 1);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_d;

  // Cleared only on a confirmed press, so an aborted release (DB_UP back to
  // HELD) keeps counting and LONG can fire at most once per press. Leaving
  // for IDLE takes priority, which also keeps LONG and RELEASE exclusive.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (press_d) begin
      long_cnt_d = '0;
    end else if (state_d == IDLE) begin
      long_cnt_d = '0;
    end else if (is_pressed(state_q) && (long_cnt_q != LONG_MAX)) begin
      long_cnt_d = long_cnt_q + LW'(1);
      long_d     = (long_cnt_q == LONG_LAST);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      long_cnt_q <= '0;
      LONG       <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      LONG       <= long_d;
    end
  end
`else
  logic [LW-1:0] unused_long_limit;
  assign unused_long_limit = LW'(T_LONG);
  assign LONG = 1'b0;
`endif

endmodule

// File: rtl/key_multi_funcmod.sv
// rtl/key_multi_funcmod.sv - N_KEY independent active-low key debouncers
//
// Purpose : generates one key_channel_funcmod per key and concatenates the
//           per-channel pulses and levels into N_KEY-wide buses.
// Ports   : CLOCK   in  system clock, posedge
//           RESET   in  asynchronous active-low reset
//           KEY     in  [N_KEY] raw key pins, active-low, idle high
//           PRESS   out [N_KEY] one-cycle press pulses
//           RELEASE out [N_KEY] one-cycle release pulses
//           LONG    out [N_KEY] one-cycle long-press pulses
//           STATE   out [N_KEY] debounced levels, 1 = pressed
// Config  : KEY_LONGPRESS_EN enables the long-press counters in every channel.
module key_multi_funcmod
  import key_pkg::*;
#(
  parameter int N_KEY      = 4,
  parameter int T_DEBOUNCE = T_DEBOUNCE_DEFAULT,
  parameter int T_LONG     = T_LONG_DEFAULT
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [N_KEY-1:0] KEY,
  output logic [N_KEY-1:0] PRESS,
  output logic [N_KEY-1:0] RELEASE,
  output logic [N_KEY-1:0] LONG,
  output logic [N_KEY-1:0] STATE
);

  for (genvar g = 0; g < N_KEY; g++) begin : g_key
    key_channel_funcmod #(
      .T_DEBOUNCE (T_DEBOUNCE),
      .T_LONG     (T_LONG)
    ) u_channel (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .KEY     (KEY[g]),
      .PRESS   (PRESS[g]),
      .RELEASE (RELEASE[g]),
      .LONG    (LONG[g]),
      .STATE   (STATE[g])
    );
  end

endmodule

// File: tb/tb_key_multi_funcmod.sv
// tb/tb_key_multi_funcmod.sv - directed self-checking bench for key_multi_funcmod
module tb_key_multi_funcmod;

  localparam int N_KEY      = 4;
  localparam int T_DEBOUNCE = 8;
  localparam int T_LONG     = 40;
  localparam int LAT        = T_DEBOUNCE + 3;
`ifdef KEY_LONGPRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b0;
  logic [N_KEY-1:0] KEY   = '1;
  logic [N_KEY-1:0] PRESS, RELEASE, LONG, STATE;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int press_cnt [N_KEY] = '{default: 0};
  int rel_cnt   [N_KEY] = '{default: 0};
  int long_cnt  [N_KEY] = '{default: 0};
  int press_cyc [N_KEY] = '{default: -1};
  int rel_cyc   [N_KEY] = '{default: -1};
  int long_cyc  [N_KEY] = '{default: -1};
  int state_hi  [N_KEY] = '{default: 0};
  int press_all = 0;
  int rel_all   = 0;
  int excl_viol = 0;

  key_multi_funcmod #(
    .N_KEY      (N_KEY),
    .T_DEBOUNCE (T_DEBOUNCE),
    .T_LONG     (T_LONG)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .KEY     (KEY),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .LONG    (LONG),
    .STATE   (STATE)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Recorder: pulse counts and the edge number each pulse followed.
  always @(negedge CLOCK) begin
    for (int i = 0; i < N_KEY; i++) begin
      if (PRESS[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (RELEASE[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
      if (LONG[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      if (STATE[i])   state_hi[i]++;
      if (int'(PRESS[i]) + int'(RELEASE[i]) + int'(LONG[i]) > 1) excl_viol++;
    end
    if (PRESS == 4'hF)   press_all++;
    if (RELEASE == 4'hF) rel_all++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < N_KEY; i++) s += press_cnt[i] + rel_cnt[i] + long_cnt[i];
    return s;
  endfunction

  function automatic int total_state();
    int s = 0;
    for (int i = 0; i < N_KEY; i++) s += state_hi[i];
    return s;
  endfunction

  task automatic test_reset();
    RESET = 1'b0;
    KEY   = '1;
    tick(3);
    n_checks++;
    if (PRESS !== 4'h0) begin n_fail++; $display("FAIL reset_press got %b want 0000", PRESS); end
    n_checks++;
    if (RELEASE !== 4'h0) begin n_fail++; $display("FAIL reset_release got %b want 0000", RELEASE); end
    n_checks++;
    if (LONG !== 4'h0) begin n_fail++; $display("FAIL reset_long got %b want 0000", LONG); end
    n_checks++;
    if (STATE !== 4'h0) begin n_fail++; $display("FAIL reset_state got %b want 0000", STATE); end
    RESET = 1'b1;
    tick(5);
    n_checks++;
    if (total_pulses() !== 0) begin n_fail++; $display("FAIL idle_pulses got %0d want 0", total_pulses()); end
  endtask

  task automatic test_clean_press();
    int e0, r0, p0, rl0, l0;
    p0 = press_cnt[0]; rl0 = rel_cnt[0]; l0 = long_cnt[0];
    e0 = cyc;
    KEY[0] = 1'b0;
    tick(30);
    n_checks++;
    if (press_cnt[0] - p0 !== 1) begin n_fail++; $display("FAIL clean_press_count got %0d want 1", press_cnt[0] - p0); end
    n_checks++;
    if (press_cyc[0] !== e0 + LAT) begin n_fail++; $display("FAIL clean_press_edge got %0d want %0d", press_cyc[0], e0 + LAT); end
    n_checks++;
    if (STATE !== 4'b0001) begin n_fail++; $display("FAIL clean_state_held got %b want 0001", STATE); end
    r0 = cyc;
    KEY[0] = 1'b1;
    tick(15);
    n_checks++;
    if (rel_cnt[0] - rl0 !== 1) begin n_fail++; $display("FAIL clean_release_count got %0d want 1", rel_cnt[0] - rl0); end
    n_checks++;
    if (rel_cyc[0] !== r0 + LAT) begin n_fail++; $display("FAIL clean_release_edge got %0d want %0d", rel_cyc[0], r0 + LAT); end
    n_checks++;
    if (STATE !== 4'b0000) begin n_fail++; $display("FAIL clean_state_idle got %b want 0000", STATE); end
    n_checks++;
    if (long_cnt[0] - l0 !== 0) begin n_fail++; $display("FAIL clean_no_long got %0d want 0", long_cnt[0] - l0); end
  endtask

  task automatic test_glitch();
    int tp0, ts0;
    tp0 = total_pulses();
    ts0 = total_state();
    KEY[1] = 1'b0;
    tick(5);
    KEY[1] = 1'b1;
    tick(20);
    n_checks++;
    if (total_pulses() - tp0 !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d want 0", total_pulses() - tp0); end
    n_checks++;
    if (total_state() - ts0 !== 0) begin n_fail++; $display("FAIL glitch_state got %0d want 0", total_state() - ts0); end
  endtask

  task automatic test_release_bounce();
    int e0, r0, rl0, sh0, l0;
    rl0 = rel_cnt[2]; l0 = long_cnt[2];
    e0 = cyc;
    KEY[2] = 1'b0;
    tick(15);
    n_checks++;
    if (press_cyc[2] !== e0 + LAT) begin n_fail++; $display("FAIL bounce_press_edge got %0d want %0d", press_cyc[2], e0 + LAT); end
    sh0 = state_hi[2];
    KEY[2] = 1'b1;
    tick(3);
    KEY[2] = 1'b0;
    tick(14);
    n_checks++;
    if (state_hi[2] - sh0 !== 17) begin n_fail++; $display("FAIL bounce_state_held got %0d want 17", state_hi[2] - sh0); end
    n_checks++;
    if (rel_cnt[2] - rl0 !== 0) begin n_fail++; $display("FAIL bounce_no_release got %0d want 0", rel_cnt[2] - rl0); end
    r0 = cyc;
    KEY[2] = 1'b1;
    tick(15);
    n_checks++;
    if (rel_cyc[2] !== r0 + LAT) begin n_fail++; $display("FAIL bounce_release_edge got %0d want %0d", rel_cyc[2], r0 + LAT); end
    n_checks++;
    if (long_cnt[2] - l0 !== 0) begin n_fail++; $display("FAIL bounce_no_long got %0d want 0", long_cnt[2] - l0); end
  endtask

  task automatic test_long_press();
    int e0, r0, l0, rl0, exp_lc;
    l0 = long_cnt[3]; rl0 = rel_cnt[3];
    e0 = cyc;
    KEY[3] = 1'b0;
    tick(80);
    r0 = cyc;
    KEY[3] = 1'b1;
    tick(15);
    exp_lc = (EXP_LONG == 1) ? e0 + LAT + T_LONG : -1;
    n_checks++;
    if (press_cyc[3] !== e0 + LAT) begin n_fail++; $display("FAIL long_press_edge got %0d want %0d", press_cyc[3], e0 + LAT); end
    n_checks++;
    if (long_cnt[3] - l0 !== EXP_LONG) begin n_fail++; $display("FAIL long_count got %0d want %0d", long_cnt[3] - l0, EXP_LONG); end
    n_checks++;
    if (long_cyc[3] !== exp_lc) begin n_fail++; $display("FAIL long_edge got %0d want %0d", long_cyc[3], exp_lc); end
    n_checks++;
    if (rel_cnt[3] - rl0 !== 1) begin n_fail++; $display("FAIL long_release_count got %0d want 1", rel_cnt[3] - rl0); end
    n_checks++;
    if (rel_cyc[3] !== r0 + LAT) begin n_fail++; $display("FAIL long_release_edge got %0d want %0d", rel_cyc[3], r0 + LAT); end
  endtask

  task automatic test_simultaneous();
    int e0, pa0, ra0;
    pa0 = press_all; ra0 = rel_all;
    e0 = cyc;
    KEY = 4'h0;
    tick(15);
    n_checks++;
    if (press_all - pa0 !== 1) begin n_fail++; $display("FAIL simul_press_all got %0d want 1", press_all - pa0); end
    n_checks++;
    if (STATE !== 4'hF) begin n_fail++; $display("FAIL simul_state got %b want 1111", STATE); end
    for (int i = 0; i < N_KEY; i++) begin
      n_checks++;
      if (press_cyc[i] !== e0 + LAT) begin n_fail++; $display("FAIL simul_press_edge%0d got %0d want %0d", i, press_cyc[i], e0 + LAT); end
    end
    KEY = 4'hF;
    tick(15);
    n_checks++;
    if (rel_all - ra0 !== 1) begin n_fail++; $display("FAIL simul_release_all got %0d want 1", rel_all - ra0); end
    n_checks++;
    if (STATE !== 4'h0) begin n_fail++; $display("FAIL simul_state_idle got %b want 0000", STATE); end
  endtask

  task automatic test_reset_mid_hold();
    int e0, rl0, p0;
    KEY[0] = 1'b0;
    tick(15);
    n_checks++;
    if (STATE[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_held got %b want 1", STATE[0]); end
    rl0 = rel_cnt[0];
    RESET = 1'b0;
    #2;
    n_checks++;
    if ({PRESS, RELEASE, LONG, STATE} !== 16'h0) begin
      n_fail++; $display("FAIL midrst_clear got %h want 0000", {PRESS, RELEASE, LONG, STATE});
    end
    tick(3);
    p0 = press_cnt[0];
    RESET = 1'b1;
    e0 = cyc;
    tick(15);
    n_checks++;
    if (press_cnt[0] - p0 !== 1) begin n_fail++; $display("FAIL midrst_repress_count got %0d want 1", press_cnt[0] - p0); end
    n_checks++;
    if (press_cyc[0] !== e0 + LAT) begin n_fail++; $display("FAIL midrst_repress_edge got %0d want %0d", press_cyc[0], e0 + LAT); end
    n_checks++;
    if (rel_cnt[0] - rl0 !== 0) begin n_fail++; $display("FAIL midrst_no_release got %0d want 0", rel_cnt[0] - rl0); end
    KEY[0] = 1'b1;
    tick(15);
  endtask

  task automatic test_hold_100();
    int p0, rl0, l0;
    p0 = press_cnt[1]; rl0 = rel_cnt[1]; l0 = long_cnt[1];
    KEY[1] = 1'b0;
    tick(100);
    KEY[1] = 1'b1;
    tick(15);
    n_checks++;
    if (long_cnt[1] - l0 !== EXP_LONG) begin n_fail++; $display("FAIL hold100_long got %0d want %0d", long_cnt[1] - l0, EXP_LONG); end
    n_checks++;
    if (press_cnt[1] - p0 !== 1) begin n_fail++; $display("FAIL hold100_press got %0d want 1", press_cnt[1] - p0); end
    n_checks++;
    if (rel_cnt[1] - rl0 !== 1) begin n_fail++; $display("FAIL hold100_release got %0d want 1", rel_cnt[1] - rl0); end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (excl_viol !== 0) begin n_fail++; $display("FAIL exclusive_pulses got %0d want 0", excl_viol); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    test_hold_100();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
